// File: rtl/ldpc_dvb_dec_sink_pkg.sv
// Shared types and sizes for the LDPC DVB-S2 multi-buffer output sink.
package ldpc_dvb_dec_sink_pkg;

    localparam int cRADDR_W = 8;
    localparam int cTAG_W   = 4;
    localparam int cERR_W   = 16;
    localparam int cBUF_N   = 4;
    localparam int cBUF_W   = $clog2(cBUF_N);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        RELEASE,
        DROP
    } state_t;

    typedef struct packed {
        logic [cTAG_W-1:0]  tag;
        logic               decfail;
        logic [cERR_W-1:0]  err;
        logic [7:0]         Niter;
        logic [cRADDR_W:0]  size;
    } meta_t;

endpackage

// File: rtl/ldpc_dvb_meta_fifo.sv
// Per-buffer frame metadata queue; the read pointer doubles as the
// index of the RAM buffer currently being drained.
module ldpc_dvb_meta_fifo
    import ldpc_dvb_dec_sink_pkg::*;
#(
    parameter int pBUF_N = cBUF_N,
    parameter int pBUF_W = $clog2(pBUF_N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              push,
    input  logic              pop,
    input  meta_t             wdata,
    output meta_t             rdata,
    output logic [pBUF_W-1:0] rd_ptr,
    output logic [pBUF_W:0]   count,
    output logic              full,
    output logic              empty
);

    localparam int CNT_W = pBUF_W + 1;

    meta_t             mem [pBUF_N];
    logic [pBUF_W-1:0] wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (ena) begin
            if (push)
                wr_ptr <= wr_ptr + pBUF_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + pBUF_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (ena && push)
            mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CNT_W'(pBUF_N));
    assign empty = (count == '0);

endmodule

// File: rtl/ldpc_dvb_dec_sink_mb.sv
// Multi-buffer LDPC decoder sink: drains decoded frames from the output
// RAM ring as a pulled sop/eop/val stream with per-frame metadata.
module ldpc_dvb_dec_sink_mb
    import ldpc_dvb_dec_sink_pkg::*;
#(
    parameter int pRADDR_W = cRADDR_W,
    parameter int pRDAT_W  = 8,
    parameter int pDAT_W   = 2,
    parameter int pBUF_N   = cBUF_N,
    parameter int pRD_LAT  = 2,
    parameter int pTAG_W   = cTAG_W,
    parameter int pERR_W   = cERR_W,
    parameter int pBUF_W   = $clog2(pBUF_N)
) (
    input  logic                       iclk,
    input  logic                       ireset,
    input  logic                       iclkena,
    input  logic                       iskip_fail,
    input  logic                       irfull,
    input  logic [pRADDR_W:0]          irsize,
    input  logic [pTAG_W-1:0]          irtag,
    input  logic                       irdecfail,
    input  logic [pERR_W-1:0]          irerr,
    input  logic [7:0]                 irNiter,
    input  logic [pRDAT_W-1:0]         irdat,
    output logic [pBUF_W+pRADDR_W-1:0] oraddr,
    output logic                       orempty,
    input  logic                       ireq,
    output logic                       ofull,
    output logic                       osop,
    output logic                       oeop,
    output logic                       oval,
    output logic [pDAT_W-1:0]          odat,
    output logic [pTAG_W-1:0]          otag,
    output logic                       odecfail,
    output logic [pERR_W-1:0]          oerr,
    output logic [7:0]                 oNiter,
    output logic                       odrop,
    output logic                       ooverflow
);

    localparam int pSER   = pRDAT_W / pDAT_W;
    localparam int PH_W   = (pSER > 1) ? $clog2(pSER) : 1;
    localparam int CNT_W  = pBUF_W + 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(pSER - 1);
    localparam logic [cRADDR_W:0] SZ_ONE = 1;

    state_t              state, state_nxt;
    logic                start;
    meta_t               wmeta, head;
    logic [pBUF_W-1:0]   rd_ptr;
    logic [pBUF_W:0]     count, cnt_nxt;
    logic                full, empty;
    logic                push, pop;

    logic [pRADDR_W-1:0] addr, last_addr;
    logic [PH_W-1:0]     phase;
    logic                slot, first, last_slot;

    logic [pRD_LAT-1:0]  d_val, d_sop, d_eop;
    logic [PH_W-1:0]     d_ph [pRD_LAT];
    logic [pDAT_W-1:0]   slice [pSER];

    assign wmeta = '{tag: irtag, decfail: irdecfail, err: irerr,
                     Niter: irNiter, size: irsize};

    assign push = irfull && !full;
    assign pop  = (state == RELEASE) || (state == DROP);

    ldpc_dvb_meta_fifo #(
        .pBUF_N (pBUF_N),
        .pBUF_W (pBUF_W)
    ) u_fifo (
        .clk    (iclk),
        .rst_n  (ireset),
        .ena    (iclkena),
        .push   (push),
        .pop    (pop),
        .wdata  (wmeta),
        .rdata  (head),
        .rd_ptr (rd_ptr),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    assign last_addr = pRADDR_W'(head.size - SZ_ONE);
    assign slot      = (state == READ) && ireq;
    assign first     = (addr == '0) && (phase == '0);
    assign last_slot = (addr == last_addr) && (phase == PH_LAST);

    assign oraddr  = {rd_ptr, addr};
    assign orempty = pop && iclkena;
    assign odrop   = (state == DROP) && iclkena;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    if (head.decfail && iskip_fail) begin
                        state_nxt = DROP;
                    end else if (ireq) begin
                        state_nxt = READ;
                        start     = 1'b1;
                    end
                end
            end
            READ:    if (slot && last_slot) state_nxt = DRAIN;
            DRAIN:   if (d_val == '0) state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            DROP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset)
            state <= IDLE;
        else if (iclkena)
            state <= state_nxt;
    end

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            addr  <= '0;
            phase <= '0;
        end else if (iclkena) begin
            if (state == IDLE) begin
                addr  <= '0;
                phase <= '0;
            end else if (slot) begin
                if (phase == PH_LAST) begin
                    phase <= '0;
                    addr  <= addr + pRADDR_W'(1);
                end else begin
                    phase <= phase + PH_W'(1);
                end
            end
        end
    end

    always_comb begin
        cnt_nxt = count;
        if (push && !pop)
            cnt_nxt = count + CNT_W'(1);
        else if (pop && !push)
            cnt_nxt = count - CNT_W'(1);
    end

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            ofull     <= 1'b0;
            ooverflow <= 1'b0;
            otag      <= '0;
            odecfail  <= 1'b0;
            oerr      <= '0;
            oNiter    <= '0;
        end else if (iclkena) begin
            ofull <= (cnt_nxt != '0);
            if (irfull && full)
                ooverflow <= 1'b1;
            if (start) begin
                otag     <= head.tag;
                odecfail <= head.decfail;
                oerr     <= head.err;
                oNiter   <= head.Niter;
            end
        end
    end

    // Slot tags ride alongside the RAM read so the slice and framing
    // line up with irdat when it arrives.
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            d_val <= '0;
            d_sop <= '0;
            d_eop <= '0;
            for (int i = 0; i < pRD_LAT; i++)
                d_ph[i] <= '0;
        end else if (iclkena) begin
            d_val[0] <= slot;
            d_sop[0] <= slot && first;
            d_eop[0] <= slot && last_slot;
            d_ph[0]  <= phase;
            for (int i = 1; i < pRD_LAT; i++) begin
                d_val[i] <= d_val[i-1];
                d_sop[i] <= d_sop[i-1];
                d_eop[i] <= d_eop[i-1];
                d_ph[i]  <= d_ph[i-1];
            end
        end
    end

    for (genvar k = 0; k < pSER; k++) begin : g_slice
        assign slice[k] = irdat[k*pDAT_W +: pDAT_W];
    end

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            oval <= 1'b0;
            osop <= 1'b0;
            oeop <= 1'b0;
            odat <= '0;
        end else if (iclkena) begin
            oval <= d_val[pRD_LAT-1];
            osop <= d_val[pRD_LAT-1] && d_sop[pRD_LAT-1];
            oeop <= d_val[pRD_LAT-1] && d_eop[pRD_LAT-1];
            if (d_val[pRD_LAT-1])
                odat <= slice[d_ph[pRD_LAT-1]];
        end
    end

endmodule

// File: tb/tb_ldpc_dvb_dec_sink_mb.sv
// Self-checking bench for ldpc_dvb_dec_sink_mb: table-driven frames
// plus hand sequences, with a scoreboard of expected stream words.
module tb_ldpc_dvb_dec_sink_mb;

    localparam int RADDR_W = 8;
    localparam int RDAT_W  = 8;
    localparam int DAT_W   = 2;
    localparam int BUF_N   = 4;
    localparam int RD_LAT  = 3;
    localparam int SER     = RDAT_W / DAT_W;

    logic        clk = 1'b0;
    logic        ireset = 1'b0;
    logic        iclkena = 1'b1;
    logic        iskip_fail = 1'b0;
    logic        irfull = 1'b0;
    logic [8:0]  irsize = '0;
    logic [3:0]  irtag = '0;
    logic        irdecfail = 1'b0;
    logic [15:0] irerr = '0;
    logic [7:0]  irNiter = '0;
    logic [7:0]  irdat;
    logic [9:0]  oraddr;
    logic        orempty, ofull, osop, oeop, oval;
    logic        ireq = 1'b0;
    logic [1:0]  odat;
    logic [3:0]  otag;
    logic        odecfail;
    logic [15:0] oerr;
    logic [7:0]  oNiter;
    logic        odrop, ooverflow;

    ldpc_dvb_dec_sink_mb #(
        .pRADDR_W (RADDR_W),
        .pRDAT_W  (RDAT_W),
        .pDAT_W   (DAT_W),
        .pBUF_N   (BUF_N),
        .pRD_LAT  (RD_LAT),
        .pTAG_W   (4),
        .pERR_W   (16)
    ) dut (
        .iclk       (clk),
        .ireset     (ireset),
        .iclkena    (iclkena),
        .iskip_fail (iskip_fail),
        .irfull     (irfull),
        .irsize     (irsize),
        .irtag      (irtag),
        .irdecfail  (irdecfail),
        .irerr      (irerr),
        .irNiter    (irNiter),
        .irdat      (irdat),
        .oraddr     (oraddr),
        .orempty    (orempty),
        .ireq       (ireq),
        .ofull      (ofull),
        .osop       (osop),
        .oeop       (oeop),
        .oval       (oval),
        .odat       (odat),
        .otag       (otag),
        .odecfail   (odecfail),
        .oerr       (oerr),
        .oNiter     (oNiter),
        .odrop      (odrop),
        .ooverflow  (ooverflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  dat;
        logic        sop;
        logic        eop;
        logic [3:0]  tag;
        logic        df;
        logic [15:0] err;
        logic [7:0]  nit;
    } exp_t;

    typedef struct {
        int          size;
        logic [3:0]  tag;
        logic        df;
        logic [15:0] err;
        logic [7:0]  nit;
        logic        skip;
        int          mode;
        int          exp_words;
        int          exp_drops;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    int   pending = 0;
    int   words = 0;
    int   drops = 0;
    int   empties = 0;
    int   mode = 0;
    logic [1:0] wp = '0;
    logic [7:0] req_hist = '0;
    exp_t q[$];
    logic [7:0] pipe [RD_LAT];

    function automatic logic [7:0] ram_word(input logic [9:0] a);
        return 8'(a * 10'd29) ^ 8'(a >> 2) ^ 8'h5A;
    endfunction

    task automatic chk(input string n, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    always @(posedge clk) begin
        pipe[0] <= ram_word(oraddr);
        for (int i = 1; i < RD_LAT; i++)
            pipe[i] <= pipe[i-1];
    end
    assign irdat = pipe[RD_LAT-1];

    always begin
        @(posedge clk);
        #1;
        case (mode)
            0:       ireq = 1'b0;
            1:       ireq = 1'b1;
            default: ireq = ~ireq;
        endcase
    end

    always @(negedge clk) begin
        exp_t e, g;
        if (ireset) begin
            if (orempty) begin
                pending--;
                empties++;
            end
            if (odrop)
                drops++;
            if (oval) begin
                words++;
                chk("word_pulled", 64'(req_hist[RD_LAT]), 64'(1));
                chk("queue_nonempty", 64'(q.size() != 0), 64'(1));
                if (q.size() != 0) begin
                    e = q.pop_front();
                    g = '{odat, osop, oeop, otag, odecfail, oerr, oNiter};
                    chk("stream_word", 64'(g), 64'(e));
                end
            end
        end
        req_hist = {req_hist[6:0], ireq};
    end

    task automatic push_frame(input int n, input logic [3:0] tag,
                              input logic df, input logic [15:0] err,
                              input logic [7:0] nit, output logic rel);
        exp_t e;
        irfull    = 1'b1;
        irsize    = 9'(n);
        irtag     = tag;
        irdecfail = df;
        irerr     = err;
        irNiter   = nit;
        if (pending < BUF_N) begin
            pending++;
            if (!(df && iskip_fail)) begin
                for (int a = 0; a < n; a++)
                    for (int k = 0; k < SER; k++) begin
                        e.dat = 2'(ram_word({wp, 8'(a)}) >> (2 * k));
                        e.sop = (a == 0) && (k == 0);
                        e.eop = (a == n - 1) && (k == SER - 1);
                        e.tag = tag;
                        e.df  = df;
                        e.err = err;
                        e.nit = nit;
                        q.push_back(e);
                    end
            end
            wp = wp + 2'd1;
        end
        @(negedge clk);
        rel = orempty;
        @(posedge clk);
        #1;
        irfull = 1'b0;
        @(negedge clk);
        chk("ofull_after_irfull", 64'(ofull), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string n);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (pending == 0 && q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(n, 64'(ok), 64'(1));
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string n);
        chk(n, {16'h0, oraddr, orempty, ofull, osop, oeop, oval, odat,
                otag, odecfail, oerr, oNiter, odrop, ooverflow}, 64'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [7];
        int   w0, d0, e0;
        logic rel, got;

        vt[0] = '{3,   4'h5, 1'b0, 16'h1234, 8'd7,  1'b0, 1, 12,   0};
        vt[1] = '{1,   4'hA, 1'b0, 16'h0001, 8'd1,  1'b0, 1, 4,    0};
        vt[2] = '{3,   4'h3, 1'b0, 16'h00FF, 8'd12, 1'b0, 2, 12,   0};
        vt[3] = '{5,   4'h9, 1'b1, 16'hBEEF, 8'd50, 1'b0, 2, 20,   0};
        vt[4] = '{2,   4'hC, 1'b1, 16'h0042, 8'd50, 1'b1, 1, 0,    1};
        vt[5] = '{256, 4'hF, 1'b0, 16'h8000, 8'd3,  1'b0, 1, 1024, 0};
        vt[6] = '{7,   4'h6, 1'b0, 16'h0777, 8'd9,  1'b1, 2, 28,   0};

        repeat (3) @(negedge clk);
        chk_reset("reset_outputs");
        @(posedge clk);
        #1;
        ireset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        foreach (vt[i]) begin
            iskip_fail = vt[i].skip;
            mode = vt[i].mode;
            w0 = words; d0 = drops; e0 = empties;
            push_frame(vt[i].size, vt[i].tag, vt[i].df, vt[i].err,
                       vt[i].nit, rel);
            wait_done($sformatf("vec%0d_done", i));
            chk($sformatf("vec%0d_words", i), 64'(words - w0),
                64'(vt[i].exp_words));
            chk($sformatf("vec%0d_drops", i), 64'(drops - d0),
                64'(vt[i].exp_drops));
            chk($sformatf("vec%0d_empties", i), 64'(empties - e0), 64'(1));
        end

        iskip_fail = 1'b0;
        mode = 0;
        w0 = words; e0 = empties;
        for (int f = 0; f < 4; f++)
            push_frame(2, 4'(f + 1), 1'b0, 16'(f), 8'(f), rel);
        chk("no_early_overflow", 64'(ooverflow), 64'(0));
        push_frame(2, 4'h5, 1'b0, 16'h5, 8'h5, rel);
        chk("overflow_sticky", 64'(ooverflow), 64'(1));
        mode = 1;
        wait_done("ovf_done");
        chk("ovf_words", 64'(words - w0), 64'(4 * 2 * SER));
        chk("ovf_empties", 64'(empties - e0), 64'(4));

        iskip_fail = 1'b1;
        w0 = words; d0 = drops; e0 = empties;
        push_frame(3, 4'h1, 1'b0, 16'h11, 8'd1, rel);
        push_frame(3, 4'h2, 1'b1, 16'h22, 8'd2, rel);
        push_frame(3, 4'h3, 1'b0, 16'h33, 8'd3, rel);
        wait_done("skip_done");
        chk("skip_words", 64'(words - w0), 64'(2 * 3 * SER));
        chk("skip_drops", 64'(drops - d0), 64'(1));
        chk("skip_empties", 64'(empties - e0), 64'(3));
        iskip_fail = 1'b0;

        w0 = words; e0 = empties;
        push_frame(3, 4'h7, 1'b0, 16'h70, 8'd7, rel);
        got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (oeop) begin
                got = 1'b1;
                break;
            end
        end
        chk("eop_seen", 64'(got), 64'(1));
        @(posedge clk);
        #1;
        push_frame(3, 4'h8, 1'b0, 16'h80, 8'd8, rel);
        chk("release_coincide", 64'(rel), 64'(1));
        wait_done("coin_done");
        chk("coin_words", 64'(words - w0), 64'(2 * 3 * SER));
        chk("coin_empties", 64'(empties - e0), 64'(2));

        w0 = words;
        push_frame(4, 4'hB, 1'b0, 16'hB0, 8'd11, rel);
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (words >= w0 + 3) begin
                got = 1'b1;
                break;
            end
        end
        chk("mid_read_reached", 64'(got), 64'(1));
        @(posedge clk);
        #1;
        ireset = 1'b0;
        @(negedge clk);
        chk_reset("mid_reset_outputs");
        q.delete();
        pending = 0;
        wp = '0;
        @(posedge clk);
        #1;
        ireset = 1'b1;
        @(posedge clk);
        #1;
        w0 = words; e0 = empties;
        push_frame(2, 4'h4, 1'b0, 16'h44, 8'd4, rel);
        wait_done("post_reset_done");
        chk("post_reset_words", 64'(words - w0), 64'(2 * SER));
        chk("post_reset_empties", 64'(empties - e0), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
